// File: rtl/snoopy_bus_arbiter_if.sv
// Snoopy bus arbiter interface: per-cache request/command inputs, snoop
// responses from every cache, and the arbiter's registered grant/broadcast
// outputs. The master modport is the arbiter; the slave modport is the
// cache-controller side.
interface snoopy_bus_arbiter_if #(
    parameter int NUM_CACHES    = 4,
    parameter int COMMAND_WIDTH = 2
);
    localparam int ID_WIDTH = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1;

    logic [NUM_CACHES-1:0]               request;
    logic [NUM_CACHES*COMMAND_WIDTH-1:0] commandIn;
    logic [NUM_CACHES-1:0]               grant;
    logic [COMMAND_WIDTH-1:0]            commandOut;
    logic                                commandValid;
    logic [ID_WIDTH-1:0]                 sourceId;
    logic [NUM_CACHES-1:0]               snoopRequest;
    logic [NUM_CACHES-1:0]               sharedIn;
    logic                                sharedOut;
    logic [NUM_CACHES-1:0]               supplierGrant;
    logic                                memoryRequest;
    logic                                done;

    modport master (
        input  request, commandIn, snoopRequest, sharedIn, done,
        output grant, commandOut, commandValid, sourceId,
               sharedOut, supplierGrant, memoryRequest
    );

    modport slave (
        output request, commandIn, snoopRequest, sharedIn, done,
        input  grant, commandOut, commandValid, sourceId,
               sharedOut, supplierGrant, memoryRequest
    );
endinterface

// File: rtl/snoopy_bus_arbiter.sv
// Snoopy bus arbiter: round-robin selection of one initiator, one-cycle snoop
// broadcast, then either a data phase (cache-to-cache or memory) ending on
// done, or straight to release for non-data commands. All outputs registered.
module snoopy_bus_arbiter #(
    parameter int NUM_CACHES    = 4,
    parameter int COMMAND_WIDTH = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    snoopy_bus_arbiter_if.master bus
);
    localparam int ID_WIDTH = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1;

    // Bus command encoding
    localparam logic [COMMAND_WIDTH-1:0] BUS_READ           = COMMAND_WIDTH'(1);
    localparam logic [COMMAND_WIDTH-1:0] BUS_READ_EXCLUSIVE = COMMAND_WIDTH'(2);

    typedef enum logic [1:0] {
        IDLE,
        SNOOP,
        TRANSFER,
        RELEASE
    } state_t;

    state_t                   r_state;
    logic [ID_WIDTH-1:0]      r_ptr;
    logic [NUM_CACHES-1:0]    r_grant;
    logic [COMMAND_WIDTH-1:0] r_command;
    logic                     r_valid;
    logic [ID_WIDTH-1:0]      r_source;
    logic                     r_shared;
    logic [NUM_CACHES-1:0]    r_supplier;
    logic                     r_mem;

    logic                     w_sel_found;
    logic [ID_WIDTH-1:0]      w_sel_idx;
    logic [COMMAND_WIDTH-1:0] w_sel_cmd;
    logic [NUM_CACHES-1:0]    w_self_mask;
    logic [NUM_CACHES-1:0]    w_snoop_masked;
    logic [NUM_CACHES-1:0]    w_shared_masked;
    logic                     w_sup_found;
    logic [NUM_CACHES-1:0]    w_sup_onehot;
    logic                     w_is_data;
    logic [ID_WIDTH-1:0]      w_next_ptr;

    assign bus.grant         = r_grant;
    assign bus.commandOut    = r_command;
    assign bus.commandValid  = r_valid;
    assign bus.sourceId      = r_source;
    assign bus.sharedOut     = r_shared;
    assign bus.supplierGrant = r_supplier;
    assign bus.memoryRequest = r_mem;

    assign w_self_mask     = ~(NUM_CACHES'(1) << r_source);
    assign w_snoop_masked  = bus.snoopRequest & w_self_mask;
    assign w_shared_masked = bus.sharedIn & w_self_mask;
    assign w_is_data       = (r_command == BUS_READ) || (r_command == BUS_READ_EXCLUSIVE);
    assign w_next_ptr      = (r_source == ID_WIDTH'(NUM_CACHES - 1)) ? '0 : r_source + 1'b1;

    // Round-robin pick: first requester at or after the pointer, wrapping
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_sel_cmd   = '0;
        for (int unsigned k = 0; k < NUM_CACHES; k++) begin
            for (int unsigned i = 0; i < NUM_CACHES; i++) begin
                if (!w_sel_found && bus.request[i]
                    && (i == (int'(r_ptr) + k) % NUM_CACHES)) begin
                    w_sel_found = 1'b1;
                    w_sel_idx   = ID_WIDTH'(i);
                    w_sel_cmd   = bus.commandIn[i*COMMAND_WIDTH +: COMMAND_WIDTH];
                end
            end
        end
    end

    // Supplier is the lowest-indexed cache offering data (initiator excluded)
    always_comb begin
        w_sup_found  = 1'b0;
        w_sup_onehot = '0;
        for (int unsigned i = 0; i < NUM_CACHES; i++) begin
            if (!w_sup_found && w_snoop_masked[i]) begin
                w_sup_found  = 1'b1;
                w_sup_onehot = NUM_CACHES'(1) << i;
            end
        end
    end

    // Transaction FSM with registered bus outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_grant    <= '0;
            r_command  <= '0;
            r_valid    <= 1'b0;
            r_source   <= '0;
            r_shared   <= 1'b0;
            r_supplier <= '0;
            r_mem      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_sel_found) begin
                        r_grant   <= NUM_CACHES'(1) << w_sel_idx;
                        r_source  <= w_sel_idx;
                        r_command <= w_sel_cmd;
                        r_valid   <= 1'b1;
                        r_state   <= SNOOP;
                    end
                end
                SNOOP: begin
                    r_valid <= 1'b0;
                    if (w_is_data) begin
                        r_shared <= |w_shared_masked;
                        if (w_sup_found) begin
                            r_supplier <= w_sup_onehot;
                            r_mem      <= 1'b0;
                        end else begin
                            r_supplier <= '0;
                            r_mem      <= 1'b1;
                        end
                        r_state <= TRANSFER;
                    end else begin
                        r_grant <= '0;
                        r_state <= RELEASE;
                    end
                end
                TRANSFER: begin
                    if (bus.done) begin
                        r_grant    <= '0;
                        r_supplier <= '0;
                        r_mem      <= 1'b0;
                        r_shared   <= 1'b0;
                        r_state    <= RELEASE;
                    end
                end
                RELEASE: begin
                    r_ptr   <= w_next_ptr;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_snoopy_bus_arbiter.sv
// Testbench for snoopy_bus_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_snoopy_bus_arbiter;
    localparam int N  = 4;
    localparam int CW = 2;

    localparam logic [CW-1:0] BUS_READ           = 2'd1;
    localparam logic [CW-1:0] BUS_READ_EXCLUSIVE = 2'd2;
    localparam logic [CW-1:0] BUS_INVALIDATE     = 2'd3;

    logic clock = 1'b0;
    logic reset = 1'b0;

    snoopy_bus_arbiter_if #(.NUM_CACHES(N), .COMMAND_WIDTH(CW)) bus ();

    snoopy_bus_arbiter #(.NUM_CACHES(N), .COMMAND_WIDTH(CW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;
    int m_ptr       = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Round-robin winner from the model pointer
    function automatic int pick(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] lowest_bit(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return N'(1) << i;
        end
        return '0;
    endfunction

    task automatic check_quiet(input string tag);
        check_eq({tag, ".grant"},    32'(bus.grant),         32'(0));
        check_eq({tag, ".supplier"}, 32'(bus.supplierGrant), 32'(0));
        check_eq({tag, ".memReq"},   32'(bus.memoryRequest), 32'(0));
        check_eq({tag, ".shared"},   32'(bus.sharedOut),     32'(0));
        check_eq({tag, ".valid"},    32'(bus.commandValid),  32'(0));
    endtask

    // One full transaction; starts in IDLE, or in RELEASE when in_release=1,
    // and always leaves the DUT in its RELEASE cycle.
    task automatic run_txn(input logic [N-1:0] req, input logic [N*CW-1:0] cmds,
                           input logic [N-1:0] snp, input logic [N-1:0] shr,
                           input int xfer_wait, input bit in_release);
        int            w;
        logic [CW-1:0] cmd;
        logic [N-1:0]  self_mask;
        logic [N-1:0]  exp_sup;
        logic          exp_mem;
        logic          exp_sh;
        bit            is_data;

        bus.request      = req;
        bus.commandIn    = cmds;
        bus.snoopRequest = N'($urandom);
        bus.sharedIn     = N'($urandom);
        bus.done         = 1'($urandom_range(0, 1));
        if (in_release) begin
            step();
            check_eq("gap.grant", 32'(bus.grant), 32'(0));
        end

        w   = pick(req, m_ptr);
        cmd = cmds[w*CW +: CW];
        step();
        check_eq("snoop.grant",    32'(bus.grant),         32'(N'(1) << w));
        check_eq("snoop.sourceId", 32'(bus.sourceId),      32'(w));
        check_eq("snoop.cmdOut",   32'(bus.commandOut),    32'(cmd));
        check_eq("snoop.valid",    32'(bus.commandValid),  32'(1));
        check_eq("snoop.memReq",   32'(bus.memoryRequest), 32'(0));
        check_eq("snoop.supplier", 32'(bus.supplierGrant), 32'(0));

        self_mask = ~(N'(1) << w);
        is_data   = (cmd == BUS_READ) || (cmd == BUS_READ_EXCLUSIVE);
        exp_sup   = lowest_bit(snp & self_mask);
        exp_mem   = ((snp & self_mask) == '0);
        exp_sh    = |(shr & self_mask);

        bus.snoopRequest = snp;
        bus.sharedIn     = shr;
        bus.request      = N'($urandom);
        bus.commandIn    = (N*CW)'($urandom);
        bus.done         = 1'($urandom_range(0, 1));
        step();
        bus.snoopRequest = N'($urandom);
        bus.sharedIn     = N'($urandom);
        bus.done         = 1'b0;

        if (is_data) begin
            for (int c = 0; c <= xfer_wait; c++) begin
                check_eq("xfer.grant",    32'(bus.grant),         32'(N'(1) << w));
                check_eq("xfer.sourceId", 32'(bus.sourceId),      32'(w));
                check_eq("xfer.cmdOut",   32'(bus.commandOut),    32'(cmd));
                check_eq("xfer.valid",    32'(bus.commandValid),  32'(0));
                check_eq("xfer.shared",   32'(bus.sharedOut),     32'(exp_sh));
                check_eq("xfer.supplier", 32'(bus.supplierGrant), 32'(exp_sup));
                check_eq("xfer.memReq",   32'(bus.memoryRequest), 32'(exp_mem));
                bus.request = N'($urandom);
                bus.done    = (c == xfer_wait);
                step();
            end
            bus.done = 1'b0;
        end
        check_quiet("release");
        m_ptr = (w + 1) % N;
    endtask

    function automatic logic [N*CW-1:0] one_cmd(input int idx, input logic [CW-1:0] c);
        logic [N*CW-1:0] v;
        v = '0;
        v[idx*CW +: CW] = c;
        return v;
    endfunction

    initial begin
        bit rel;
        logic [N-1:0] rq;

        bus.request      = '0;
        bus.commandIn    = '0;
        bus.snoopRequest = '0;
        bus.sharedIn     = '0;
        bus.done         = 1'b0;

        #1;
        check_quiet("reset");
        check_eq("reset.cmdOut",   32'(bus.commandOut), 32'(0));
        check_eq("reset.sourceId", 32'(bus.sourceId),   32'(0));
        step();
        step();
        reset = 1'b1;
        m_ptr = 0;

        // Single read, no sharers: memory serves, pointer moves to 1
        run_txn(4'b0001, one_cmd(0, BUS_READ), 4'b0000, 4'b0000, 1, 1'b0);
        // Pointer at 1 picks cache 1 over cache 0
        run_txn(4'b0011, one_cmd(0, BUS_READ) | one_cmd(1, BUS_INVALIDATE), '0, '0, 0, 1'b1);
        // Round-robin with everyone requesting, back to back
        for (int t = 0; t < 5; t++) begin
            run_txn(4'b1111, {BUS_INVALIDATE, BUS_READ, BUS_READ_EXCLUSIVE, BUS_INVALIDATE},
                    4'b0000, 4'b0000, 0, 1'b1);
        end
        // Cache-to-cache: supplier is lowest masked responder
        run_txn(4'b0100, one_cmd(2, BUS_READ), 4'b1010, 4'b1010, 2, 1'b1);
        // Invalidate: no data phase
        run_txn(4'b1000, one_cmd(3, BUS_INVALIDATE), 4'b1111, 4'b1111, 0, 1'b1);
        // Self-mask: initiator's own responses are ignored
        run_txn(4'b0010, one_cmd(1, BUS_READ_EXCLUSIVE), 4'b0010, 4'b0010, 0, 1'b1);

        // Randomized transactions with occasional idle gaps
        rel = 1'b1;
        for (int t = 0; t < 150; t++) begin
            rq = N'($urandom);
            if (rq == '0) rq = N'(1) << $urandom_range(0, N - 1);
            run_txn(rq, (N*CW)'($urandom), N'($urandom), N'($urandom),
                    $urandom_range(0, 3), rel);
            rel = 1'b1;
            if ($urandom_range(0, 3) == 0) begin
                bus.request = '0;
                step();
                check_eq("idle.grant", 32'(bus.grant), 32'(0));
                rel = 1'b0;
            end
        end

        // Reset in the middle of a data transfer
        bus.request = '0;
        step();
        bus.request   = 4'b0100;
        bus.commandIn = one_cmd(2, BUS_READ);
        step();
        check_eq("rst.pre.grant", 32'(bus.grant), 32'(4'b0100));
        bus.snoopRequest = '0;
        bus.sharedIn     = '0;
        step();
        check_eq("rst.pre.memReq", 32'(bus.memoryRequest), 32'(1));
        step();
        #2;
        reset = 1'b0;
        #1;
        check_quiet("rst.async");
        check_eq("rst.async.cmdOut",   32'(bus.commandOut), 32'(0));
        check_eq("rst.async.sourceId", 32'(bus.sourceId),   32'(0));
        step();
        step();
        reset = 1'b1;
        m_ptr = 0;
        run_txn(4'b0110, one_cmd(1, BUS_READ) | one_cmd(2, BUS_READ), 4'b0100, 4'b0000, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard stop so the bench can never hang
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
